// File: rtl/delay_mix.sv
// Dry/wet mixer and feedback stage for the delay datapath.
// One shared signed multiplier, sequenced over a fixed 5-cycle schedule.
module delay_mix #(
  parameter int DW = 16,
  parameter int GW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dry_in,
  input  logic [DW-1:0] wet_in,
  input  logic [GW-1:0] mix_gain,
  input  logic [GW-1:0] fb_gain,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] dac_out,
  output logic [DW-1:0] ram_out
);

  localparam int AW = DW + GW + 4;

  typedef enum logic [2:0] {IDLE, MD, MW, MF, SAT} state_t;

  state_t state, state_nxt;

  logic signed [DW:0]   d_q, w_q;
  logic [GW-1:0]        m_q, f_q;
  logic signed [AW-1:0] acc_q, p_q;

  logic [GW:0]          dry_gain;
  logic signed [DW:0]   mul_a;
  logic signed [GW+1:0] mul_b;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] d_ext, p_sh, mix_sh, fb_sum;

  // 256-m needs one extra bit; m=0 gives exactly 256
  assign dry_gain = {1'b1, {GW{1'b0}}} - {1'b0, m_q};

  always_comb begin
    mul_a = d_q;
    mul_b = {1'b0, dry_gain};
    case (state)
      MW:      begin mul_a = w_q; mul_b = {2'b00, m_q}; end
      MF:      begin mul_a = w_q; mul_b = {2'b00, f_q}; end
      default: ;
    endcase
  end

  // Product formed at accumulator width; both operands signed so it sign-extends
  assign prod   = mul_a * mul_b;
  assign d_ext  = d_q;
  assign p_sh   = p_q >>> GW;
  assign mix_sh = acc_q >>> GW;
  assign fb_sum = d_ext + p_sh;

  // Clamp to DW-bit two's complement, then flip MSB back to offset-binary
  function automatic logic [DW-1:0] sat_ob(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] hi, lo;
    hi = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    lo = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    if (v > hi)      sat_ob = {DW{1'b1}};
    else if (v < lo) sat_ob = '0;
    else             sat_ob = {~v[DW-1], v[DW-2:0]};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MD;
      MD:      state_nxt = MW;
      MW:      state_nxt = MF;
      MF:      state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      d_q     <= '0;
      w_q     <= '0;
      m_q     <= '0;
      f_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      done    <= 1'b0;
      dac_out <= {1'b1, {(DW-1){1'b0}}};
      ram_out <= {1'b1, {(DW-1){1'b0}}};
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          d_q <= {~dry_in[DW-1], ~dry_in[DW-1], dry_in[DW-2:0]};
          w_q <= {~wet_in[DW-1], ~wet_in[DW-1], wet_in[DW-2:0]};
          m_q <= mix_gain;
          f_q <= fb_gain;
        end
        MD:  acc_q <= prod;
        MW:  acc_q <= acc_q + prod;
        MF:  p_q   <= prod;
        SAT: begin
          dac_out <= sat_ob(mix_sh);
          ram_out <= sat_ob(fb_sum);
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
